mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; legal values 4..32.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset; it is sampled on the rising edge of clk.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: op_a  input  WIDTH  multiplicand, captured when start is accepted.
REQ-006 SHALL have port: op_b  input  WIDTH  multiplier, captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while in RUN.
REQ-008 SHALL have port: done  output  1  single-cycle pulse when the product is valid.
REQ-009 SHALL have port: acc_out  output  WIDTH  ACC register, which holds the product high half.
REQ-010 SHALL have port: mr_out  output  WIDTH  MR register, which holds the product low half.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE. Transitions: IDLE->RUN on start; RUN->DONE after WIDTH steps; DONE->IDLE unconditionally.
REQ-012 SHALL, on start in IDLE: set M=op_a, ACC=0, MR=op_b, step counter=0, Q=0 (Booth bit), and enter RUN on the next edge.
REQ-013 SHALL perform exactly one add/shift step per RUN cycle and increment the counter each step; the last step occurs when counter==WIDTH-1.
REQ-014 SHALL, in unsigned mode, compute {C,ACC}=ACC+(MR[0]?M:0) with a carry C, then shift {C,ACC,MR} right by 1.
REQ-015 SHALL, in signed mode, select the operation from {MR[0],Q}: 01 adds M, 10 subtracts M, 00 and 11 apply no change. Arithmetic uses a WIDTH+1-bit sign-extended adder, followed by an arithmetic right shift of {ACC,MR,Q}.
REQ-016 SHALL give a latency of WIDTH+1 cycles: with start accepted at edge T, done is high during the cycle following edge T+WIDTH+1.
REQ-017 SHALL assert busy in RUN only; done SHALL be high in DONE only, for exactly one cycle.
REQ-018 SHALL ignore start while in RUN or DONE, with no queuing; back-to-back operations are therefore spaced by at least WIDTH+2 cycles.
REQ-019 SHALL hold acc_out and mr_out stable from DONE until the next accepted start, and SHALL NOT clear them on the return to IDLE.
REQ-020 SHALL NOT let changes to op_a or op_b after acceptance affect the result.
REQ-021 SHALL return the full 2*WIDTH-bit product {acc_out,mr_out} with no overflow in either mode, including for M equal to the most negative value.

Reset
REQ-022 SHALL, when rst==0 at a clock edge, force state=IDLE and busy=0, done=0, acc_out=0, mr_out=0, M=0, counter=0, Q=0.
REQ-023 SHALL abort an operation in progress when reset occurs mid-RUN or in DONE; no done pulse SHALL follow.
REQ-024 SHALL give reset priority over start when both are active at the same edge.

Configuration
REQ-025 SHALL, when macro MUL_SEQUENCER_SIGNED_EN is defined, compile in radix-2 Booth signed multiplication per REQ-015.
REQ-026 SHALL, when MUL_SEQUENCER_SIGNED_EN is undefined, compile in unsigned shift-add per REQ-014 only. Ports and latency SHALL be identical in both builds.

Verification
REQ-027 SHALL cover, in the unsigned build: op_a=3, op_b=5, start pulse -> done 17 cycles after acceptance, acc_out=0x0000, mr_out=0x000F.
REQ-028 SHALL cover, in the unsigned build: op_a=0xFFFF, op_b=0xFFFF -> acc_out=0xFFFE, mr_out=0x0001.
REQ-029 SHALL cover, in the signed build: op_a=0xFFFD (-3), op_b=5 -> acc_out=0xFFFF, mr_out=0xFFF1; and op_a=0x8000, op_b=0x8000 -> acc_out=0x4000, mr_out=0x0000.
REQ-030 SHALL cover: start held high for 40 cycles with op_b changed mid-RUN -> exactly two done pulses, 18 cycles apart, and the first result uses the original op_b.
REQ-031 SHALL cover: rst=0 for one cycle at step 8 of RUN -> next cycle busy=0, done=0, outputs=0, and no done pulse follows.
REQ-032 SHALL cover: rst=0 and start=1 at the same edge -> remains in IDLE with busy=0.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer -- iterative multiplier, one add/shift step per clock.
//
// Purpose:
//   Multiplies op_a (M) by op_b (MR) over WIDTH RUN cycles and returns the
//   full 2*WIDTH-bit product as {acc_out, mr_out}.
//   Default build: unsigned shift-add. With MUL_SEQUENCER_SIGNED_EN defined:
//   radix-2 Booth signed multiply. Ports and latency match in both builds.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-low reset
//   start      in   begin a multiply (looked at only in IDLE)
//   op_a       in   [WIDTH-1:0] multiplicand, captured on accepted start
//   op_b       in   [WIDTH-1:0] multiplier, captured on accepted start
//   busy       out  high while the multiply is running
//   done       out  one-cycle pulse, product valid on acc_out/mr_out
//   acc_out    out  [WIDTH-1:0] product high half (ACC)
//   mr_out     out  [WIDTH-1:0] product low half (MR)
//   state_dbg  out  [1:0] current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a request with no ready. It is accepted only at a
// rising edge where the FSM is in IDLE; at any other time it is ignored and
// never queued. Operands are sampled at that edge only. done pulses for one
// cycle per accepted start, and the product stays on acc_out/mr_out until
// the next accepted start or reset.
//
// busy and done are registered copies of the state, so they appear one
// cycle after the state enters RUN/DONE. This gives done WIDTH+1 cycles
// after the accepting edge.
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] mr_out,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum;

`ifdef MUL_SEQUENCER_SIGNED_EN
  logic             q_q, q_d;
  logic [WIDTH:0]   acc_x;
  logic [WIDTH:0]   m_x;

  // One extra sign bit keeps ACC - M exact even when M is the most
  // negative value; sum[WIDTH] is then the true sign for the shift.
  assign acc_x = {acc_q[WIDTH-1], acc_q};
  assign m_x   = {m_q[WIDTH-1], m_q};

  always_comb begin
    case ({mr_q[0], q_q})
      2'b01:   sum = acc_x + m_x;
      2'b10:   sum = acc_x - m_x;
      default: sum = acc_x;
    endcase
  end
`else
  // sum[WIDTH] is the carry C that shifts back into ACC's top bit.
  assign sum = {1'b0, acc_q} + (mr_q[0] ? {1'b0, m_q} : '0);
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
`ifdef MUL_SEQUENCER_SIGNED_EN
    q_d     = q_q;
`endif
    busy_d  = (state_q == S_RUN);
    done_d  = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = op_a;
          acc_d   = '0;
          mr_d    = op_b;
          cnt_d   = '0;
`ifdef MUL_SEQUENCER_SIGNED_EN
          q_d     = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Right shift of {sum, MR} (and Q in the Booth build).
        acc_d = sum[WIDTH:1];
        mr_d  = {sum[0], mr_q[WIDTH-1:1]};
`ifdef MUL_SEQUENCER_SIGNED_EN
        q_d   = mr_q[0];
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
`ifdef MUL_SEQUENCER_SIGNED_EN
      q_q     <= 1'b0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
`ifdef MUL_SEQUENCER_SIGNED_EN
      q_q     <= q_d;
`endif
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_out   = acc_q;
  assign mr_out    = mr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer -- directed bench for mul_sequencer (WIDTH=16).
// Builds the unsigned or Booth vector set to match MUL_SEQUENCER_SIGNED_EN.
module tb_mul_sequencer;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] acc_out;
  logic [W-1:0] mr_out;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*W-1:0] exp_q[$];

  mul_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .mr_out    (mr_out),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One multiply: accept, scramble operands, wait for done, check result,
  // latency, pulse width and hold after return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] prod);
    int             lat;
    bit             found;
    logic [2*W-1:0] exp;
    exp_q.push_back(prod);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (done) found = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'd17);
    exp = exp_q.pop_front();
    if (found) begin
      check({tag, " product"}, {acc_out, mr_out}, exp);
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " done_width"}, 32'(done), 32'd0);
      check({tag, " hold"}, {acc_out, mr_out}, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t_first, t_second, n_pulses, lat;
    logic [31:0] r_first, r_second;
    bit found;

    rst   = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    do_reset();

    check("reset acc", 32'(acc_out), 32'd0);
    check("reset mr", 32'(mr_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);

    // Directed vectors with hand-computed products.
    run_op("3x5", 16'h0003, 16'h0005, 32'h0000_000F);
`ifdef MUL_SEQUENCER_SIGNED_EN
    run_op("m3x5",     16'hFFFD, 16'h0005, 32'hFFFF_FFF1);
    run_op("min_min",  16'h8000, 16'h8000, 32'h4000_0000);
    run_op("m1xm1",    16'hFFFF, 16'hFFFF, 32'h0000_0001);
    run_op("max_min",  16'h7FFF, 16'h8000, 32'hC000_8000);
    run_op("zero",     16'h0000, 16'hABCD, 32'h0000_0000);
`else
    run_op("ffxff",    16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_op("1234x10",  16'h1234, 16'h0010, 32'h0001_2340);
    run_op("8000x2",   16'h8000, 16'h0002, 32'h0001_0000);
    run_op("ffx101",   16'h00FF, 16'h0101, 32'h0000_FFFF);
    run_op("zero",     16'h0000, 16'hABCD, 32'h0000_0000);
`endif

    // Start held for 40 cycles, op_b changed mid-RUN of the first op.
    @(negedge clk);
    op_a     = 16'h0003;
    op_b     = 16'h0005;
    start    = 1'b1;
    n_pulses = 0;
    t_first  = -1;
    t_second = -1;
    r_first  = '0;
    r_second = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) op_b = 16'h0007;
      if (done) begin
        n_pulses++;
        if (n_pulses == 1) begin
          t_first = k;
          r_first = {acc_out, mr_out};
        end else if (n_pulses == 2) begin
          t_second = k;
          r_second = {acc_out, mr_out};
        end
      end
    end
    start = 1'b0;
    check("held pulses", 32'(n_pulses), 32'd2);
    check("held first_at", 32'(t_first), 32'd17);
    check("held spacing", 32'(t_second - t_first), 32'd18);
    check("held first_result", r_first, 32'h0000_000F);
    check("held second_result", r_second, 32'h0000_0015);
    // Drain the op accepted late in the window.
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) found = 1'b1;
    end
    check("held drain_done", 32'(found), 32'd1);

    // Reset at step 8 of RUN aborts with no done pulse afterwards.
    @(negedge clk);
    op_a  = 16'h1234;
    op_b  = 16'h5678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort outputs", {acc_out, mr_out}, 32'h0000_0000);
    check("abort state", 32'(state_dbg), 32'd0);
    n_pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_pulses++;
    end
    check("abort no_activity", 32'(n_pulses), 32'd0);

    // Reset and start at the same edge: reset wins.
    @(negedge clk);
    op_a  = 16'h0003;
    op_b  = 16'h0005;
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    check("rst_start busy", 32'(busy), 32'd0);
    check("rst_start state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    check("rst_start busy_next", 32'(busy), 32'd0);
    check("rst_start state_next", 32'(state_dbg), 32'd0);

    // Normal operation after the reset cases.
    run_op("post_reset", 16'h0003, 16'h0005, 32'h0000_000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
